// File: rtl/alarm_annunciator.sv
// Sequential back end for the zone alarm detector: debounces ALARM, latches the zone pattern,
// blinks the siren until acknowledged. Optional event counter: define ALARM_EVENT_COUNT_EN.
module alarm_annunciator #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int BLINK_HALF   = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alarm_in,
  input  logic [4:0]       zone_in,
  input  logic             ack,
  output logic             siren,
  output logic             alarm_led,
  output logic [4:0]       zone_latched,
  output logic             busy,
`ifdef ALARM_EVENT_COUNT_EN
  output logic [CNT_W-1:0] event_cnt,
`endif
  output logic [1:0]       dbg_state_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_ACTIVE   = 2'd2,
    S_SILENCED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DB_W-1:0]   db_q, db_d;
  logic [BL_W-1:0]   bl_q, bl_d;
  logic              siren_q, siren_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic [4:0]        zone_q, zone_d;
  logic              trigger;

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    bl_d    = bl_q;
    siren_d = siren_q;
    led_d   = led_q;
    zone_d  = zone_q;
    trigger = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        db_d = '0;
        if (alarm_in) begin
          if (DEBOUNCE_CYC == 1) begin
            trigger = 1'b1;
          end else begin
            state_d = S_DEBOUNCE;
            db_d    = DB_W'(1);
          end
        end
      end
      S_DEBOUNCE: begin
        // Any low sample discards the accumulated count.
        if (!alarm_in) begin
          state_d = S_IDLE;
          db_d    = '0;
        end else if (db_q + DB_W'(1) == DB_LAST) begin
          trigger = 1'b1;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      S_ACTIVE: begin
        if (ack) begin
          siren_d = 1'b0;
          bl_d    = '0;
          if (alarm_in) begin
            state_d = S_SILENCED;
          end else begin
            state_d = S_IDLE;
            led_d   = 1'b0;
          end
        end else if (bl_q == BL_LAST) begin
          bl_d    = '0;
          siren_d = ~siren_q;
        end else begin
          bl_d = bl_q + BL_W'(1);
        end
      end
      S_SILENCED: begin
        siren_d = 1'b0;
        if (!alarm_in) begin
          state_d = S_IDLE;
          led_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (trigger) begin
      state_d = S_ACTIVE;
      zone_d  = zone_in;
      siren_d = 1'b1;
      led_d   = 1'b1;
      bl_d    = '0;
      db_d    = '0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      db_q    <= '0;
      bl_q    <= '0;
      siren_q <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      zone_q  <= '0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      bl_q    <= bl_d;
      siren_q <= siren_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      zone_q  <= zone_d;
    end
  end

`ifdef ALARM_EVENT_COUNT_EN
  logic [CNT_W-1:0] ev_q;

  // Saturating count of triggers; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_q <= '0;
    end else if (trigger && (ev_q != {CNT_W{1'b1}})) begin
      ev_q <= ev_q + CNT_W'(1);
    end
  end

  assign event_cnt = ev_q;
`endif

  assign siren        = siren_q;
  assign alarm_led    = led_q;
  assign zone_latched = zone_q;
  assign busy         = busy_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// Scoreboard bench for alarm_annunciator: main instance (4/3) plus a minimum-parameter instance (1/1).
module tb_alarm_annunciator;

  logic       clk = 1'b0;
  logic       rst;
  logic       alarm_in;
  logic [4:0] zone_in;
  logic       ack;

  logic       siren, alarm_led, busy;
  logic [4:0] zone_latched;
  logic [1:0] dbg_state;
  logic       siren1, alarm_led1, busy1;
  logic [4:0] zone_latched1;
  logic [1:0] dbg_state1;
`ifdef ALARM_EVENT_COUNT_EN
  logic [7:0] event_cnt, event_cnt1;
`endif

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [7:0] obs, obs1;
  assign obs  = {busy, alarm_led, siren, zone_latched};
  assign obs1 = {busy1, alarm_led1, siren1, zone_latched1};

  always #5 clk = ~clk;

  alarm_annunciator #(.DEBOUNCE_CYC(4), .BLINK_HALF(3), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .alarm_in(alarm_in), .zone_in(zone_in), .ack(ack),
    .siren(siren), .alarm_led(alarm_led), .zone_latched(zone_latched), .busy(busy),
`ifdef ALARM_EVENT_COUNT_EN
    .event_cnt(event_cnt),
`endif
    .dbg_state_o(dbg_state)
  );

  alarm_annunciator #(.DEBOUNCE_CYC(1), .BLINK_HALF(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .alarm_in(alarm_in), .zone_in(zone_in), .ack(ack),
    .siren(siren1), .alarm_led(alarm_led1), .zone_latched(zone_latched1), .busy(busy1),
`ifdef ALARM_EVENT_COUNT_EN
    .event_cnt(event_cnt1),
`endif
    .dbg_state_o(dbg_state1)
  );

  // Driver: apply inputs, let one posedge sample them, return 1 time unit later.
  task automatic drive(input logic a, input logic [4:0] z, input logic k);
    alarm_in = a;
    zone_in  = z;
    ack      = k;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h00);
      drive(1'b1, 5'b10101, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d obs=%h exp=%h", i, obs, e);
      end
      checks++;
      if (dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d obs=%0d exp=0", i, dbg_state);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_glitch();
    logic [7:0] e;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back((i < 3) ? 8'h80 : 8'h00);
      drive(i < 3, 5'b11111, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL glitch cyc=%0d obs=%h exp=%h", i, obs, e);
      end
    end
  endtask

  // Leaves the DUT in ACTIVE with zone 01100 latched.
  task automatic test_trigger_blink();
    logic [7:0] e;
    logic       s;
    int         k;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      k = i - 3;
      s = ((k / 3) % 2) == 0;
      exp_q.push_back((i < 3) ? 8'h80 : {3'b11, s, 5'b01100});
      drive(1'b1, 5'b01100, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL trigger_blink cyc=%0d obs=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_silence();
    logic [7:0] e;
    for (int i = 0; i < 6; i++) begin
      // ack to silence, hold alarm (ack ignored at i=2), then alarm low -> IDLE
      exp_q.push_back((i < 4) ? {3'b110, 5'b01100} : {3'b000, 5'b01100});
      drive(i < 4, 5'($urandom_range(0, 31)), (i == 0) || (i == 2));
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL silence cyc=%0d obs=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_latched_drop();
    logic [7:0] e;
    logic [4:0] z;
    logic       s;
    do_reset();
    z = 5'($urandom_range(1, 31));
    for (int i = 0; i < 15; i++) begin
      if (i < 3)       e = 8'h80;
      else if (i < 14) begin
        s = (((i - 3) / 3) % 2) == 0;
        e = {2'b11, s, z};
      end
      else             e = {3'b000, z};
      exp_q.push_back(e);
      if (i < 4) drive(1'b1, z, 1'b0);
      else       drive(1'b0, 5'($urandom_range(0, 31)), i == 14);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL latched_drop cyc=%0d obs=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_ack_held();
    logic [7:0] e;
    logic [4:0] z;
    do_reset();
    z = 5'($urandom_range(1, 31));
    for (int i = 0; i < 6; i++) begin
      if (i < 3)       e = 8'h80;
      else if (i == 3) e = {3'b111, z};
      else if (i == 4) e = {3'b110, z};
      else             e = {3'b000, z};
      exp_q.push_back(e);
      drive(i < 5, z, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ack_held cyc=%0d obs=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] e;
    for (int i = 0; i < 6; i++) drive(1'b1, 5'b10011, 1'b0);
    rst = 1'b1;
    exp_q.push_back(8'h00);
    drive(1'b1, 5'b10011, 1'b0);
    rst = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL rst_mid obs=%h exp=%h", obs, e);
    end
    exp_q.push_back(8'h80);
    drive(1'b1, 5'b10011, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL rst_mid_rearm obs=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_min_params();
    logic [7:0] e;
    logic [4:0] z;
    do_reset();
    z = 5'($urandom_range(1, 31));
    for (int i = 0; i < 6; i++) begin
      e = (i < 5) ? {2'b11, (i % 2) == 0, z} : {3'b000, z};
      exp_q.push_back(e);
      drive(i < 5, z, i == 5);
      e = exp_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        errors++;
        $display("FAIL min_params cyc=%0d obs=%h exp=%h", i, obs1, e);
      end
    end
  endtask

`ifdef ALARM_EVENT_COUNT_EN
  task automatic test_event_cnt();
    logic [7:0] e;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 4; i++) drive(1'b1, 5'b00111, 1'b0);
      drive(1'b0, 5'b00111, 1'b1);
    end
    exp_q.push_back(8'd3);
    e = exp_q.pop_front();
    checks++;
    if (event_cnt !== e) begin
      errors++;
      $display("FAIL event_cnt obs=%0d exp=%0d", event_cnt, e);
    end
    rst = 1'b1;
    exp_q.push_back(8'd0);
    drive(1'b0, 5'd0, 1'b0);
    rst = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (event_cnt !== e) begin
      errors++;
      $display("FAIL event_cnt_rst obs=%0d exp=%0d", event_cnt, e);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    alarm_in = 1'b0;
    zone_in  = 5'd0;
    ack      = 1'b0;
    test_reset();
    test_glitch();
    test_trigger_blink();
    test_silence();
    test_latched_drop();
    test_ack_held();
    test_rst_mid();
    test_min_params();
`ifdef ALARM_EVENT_COUNT_EN
    test_event_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
